// File: rtl/prio_encoder_seq.sv
// prio_encoder_seq
//   Registered, handshaked priority encoder. A request vector is captured
//   through a valid/ready handshake and then drained one index per accepted
//   beat, highest-priority set bit first, clearing each bit as it is emitted.
//   An all-zero capture produces a single beat flagged with out_none.
//
// Parameters
//   N    request vector width (N >= 2)
//   IW   index width, $clog2(N), derived
//
// Ports
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_vec     in   N   request vector
//   in_valid   in   1   in_vec valid
//   in_ready   out  1   block can capture a vector
//   out_idx    out  IW  index of current highest-priority pending bit
//   out_none   out  1   captured vector was all-zero (out_idx = 0)
//   out_last   out  1   final beat for the captured vector
//   out_valid  out  1   out_idx/out_none/out_last valid
//   out_ready  in   1   consumer accepts the beat
//
// Configuration
//   PENC_LSB_PRIORITY_EN  defined: lowest set bit drains first.
//                         undefined (default): highest set bit drains first.
//
// State     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for a vector; in_ready = 1, out_valid = 0
// ST_DRAIN  | emitting one index per accepted beat; in_ready = 0

module prio_encoder_seq #(
    parameter int N = 8,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  in_vec,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [IW-1:0] out_idx,
    output logic          out_none,
    output logic          out_last,
    output logic          out_valid,
    input  logic          out_ready
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  vec_q, vec_d;
    logic [N-1:0]  clr_mask;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [IW-1:0] out_idx_q, out_idx_d;
    logic          out_none_q, out_none_d;
    logic          out_last_q, out_last_d;

    function automatic logic [IW-1:0] pick_idx(input logic [N-1:0] v);
        logic [IW-1:0] idx;
        idx = '0;
`ifdef PENC_LSB_PRIORITY_EN
        // Descending scan: the last hit is the lowest set bit.
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) idx = IW'(i);
        end
`else
        // Ascending scan: the last hit is the highest set bit.
        for (int i = 0; i < N; i++) begin
            if (v[i]) idx = IW'(i);
        end
`endif
        return idx;
    endfunction

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        clr_mask = N'(1) << out_idx_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    vec_d   = in_vec;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    vec_d = vec_q & ~clr_mask;
                    if (out_last_q) begin
                        vec_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                vec_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next held vector so they can be
        // registered; nothing from in_vec reaches them combinationally.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DRAIN);
        out_idx_d   = (state_d == ST_DRAIN) ? pick_idx(vec_d) : '0;
        out_none_d  = (state_d == ST_DRAIN) && (vec_d == '0);
        // At most one bit left: clearing the lowest set bit leaves zero.
        out_last_d  = (state_d == ST_DRAIN) && ((vec_d & (vec_d - N'(1))) == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            vec_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_none_q  <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_none_q  <= out_none_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_none  = out_none_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_prio_encoder_seq.sv
// tb_prio_encoder_seq
//   Self-checking bench for prio_encoder_seq with N = 8. Expected beats come
//   from a reference drain model pushed to a queue at capture time and popped
//   as the DUT's beats are accepted. A vector table covers beat counts and
//   first index; hand sequences cover backpressure and mid-drain reset.

module tb_prio_encoder_seq;

    localparam int N  = 8;
    localparam int IW = 3;
`ifdef PENC_LSB_PRIORITY_EN
    localparam bit LSB_MODE = 1'b1;
`else
    localparam bit LSB_MODE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  in_vec;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] out_idx;
    logic          out_none;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;

    always #5 clk = ~clk;

    prio_encoder_seq #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vec    (in_vec),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_idx   (out_idx),
        .out_none  (out_none),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct packed {
        logic [IW-1:0] idx;
        logic          none;
        logic          last;
    } beat_t;

    typedef struct {
        logic [N-1:0]  vec;
        int            beats;
        logic [IW-1:0] first_idx;
        logic          first_none;
    } vec_rec_t;

    beat_t    exp_q[$];
    beat_t    held_b;
    beat_t    first_b;
    bit       held;
    int       beat_cnt;
    bit       rand_bp;
    int       checks;
    int       errors;
    vec_rec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Reference drain order, independent of the DUT's internals.
    task automatic model_push(input logic [N-1:0] v_in);
        logic [N-1:0] v;
        int           idx;
        v = v_in;
        if (v == '0) begin
            exp_q.push_back('{idx: '0, none: 1'b1, last: 1'b1});
        end else begin
            while (v != '0) begin
                idx = -1;
                for (int i = 0; i < N; i++) begin
                    if (v[i] && (LSB_MODE ? (idx < 0) : 1'b1)) idx = i;
                end
                v[idx] = 1'b0;
                exp_q.push_back('{idx: IW'(idx), none: 1'b0, last: (v == '0)});
            end
        end
    endtask

    // One cycle: observe settled outputs at the falling edge, then move to
    // just after the next rising edge where stimulus may change.
    task automatic tick();
        beat_t act;
        beat_t e;
        @(negedge clk);
        act = '{idx: out_idx, none: out_none, last: out_last};
        if (rst_n) begin
            if (out_valid) begin
                chk("ready_while_valid", {31'b0, in_ready}, 32'd0);
                if (held) chk("stall_stable", {29'b0, act}, {29'b0, held_b});
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("extra_beat", $sformatf("unexpected beat idx %0d", act.idx));
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_idx", {29'b0, act.idx}, {29'b0, e.idx});
                        chk("beat_none", {31'b0, act.none}, {31'b0, e.none});
                        chk("beat_last", {31'b0, act.last}, {31'b0, e.last});
                    end
                    if (beat_cnt == 0) first_b = act;
                    beat_cnt++;
                    held = 1'b0;
                end else begin
                    held   = 1'b1;
                    held_b = act;
                end
            end else begin
                if (held) fail_now("valid_drop", "out_valid fell without accept");
                held = 1'b0;
            end
        end else begin
            held = 1'b0;
        end
        @(posedge clk);
        #1;
        if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [N-1:0] v);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (!in_ready) fail_now("send_timeout", "in_ready never rose");
        beat_cnt = 0;
        in_vec   = v;
        in_valid = 1'b1;
        model_push(v);
        tick();
        in_valid = 1'b0;
        in_vec   = N'($urandom);
    endtask

    // Runs until the vector has drained; returns the cycles taken.
    task automatic drain(output int cycles);
        cycles = 0;
        while (!(in_ready && exp_q.size() == 0) && cycles < 300) begin
            tick();
            cycles++;
        end
        if (cycles >= 300) fail_now("drain_timeout", "vector never drained");
        out_ready = 1'b1;
    endtask

    initial begin
        int     cyc;
        int     nb;
        logic [N-1:0] rv;

        checks    = 0;
        errors    = 0;
        held      = 1'b0;
        beat_cnt  = 0;
        rand_bp   = 1'b0;
        in_vec    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;

        tbl[0] = '{8'hA4, 3, LSB_MODE ? 3'd2 : 3'd7, 1'b0};
        tbl[1] = '{8'h00, 1, 3'd0, 1'b1};
        tbl[2] = '{8'h01, 1, 3'd0, 1'b0};
        tbl[3] = '{8'hFF, 8, LSB_MODE ? 3'd0 : 3'd7, 1'b0};
        tbl[4] = '{8'h80, 1, 3'd7, 1'b0};
        tbl[5] = '{8'h55, 4, LSB_MODE ? 3'd0 : 3'd6, 1'b0};
        tbl[6] = '{8'h03, 2, LSB_MODE ? 3'd0 : 3'd1, 1'b0};

        #20;
        @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_idx", {29'b0, out_idx}, 32'd0);
        chk("rst_out_none", {31'b0, out_none}, 32'd0);
        chk("rst_out_last", {31'b0, out_last}, 32'd0);
        tick();
        chk("idle_out_valid", {31'b0, out_valid}, 32'd0);

        // Vector table at full rate: k+1 cycles per vector (capture + k beats).
        for (int t = 0; t < 7; t++) begin
            send(tbl[t].vec);
            drain(cyc);
            chk($sformatf("tbl%0d_beats", t), 32'(beat_cnt), 32'(tbl[t].beats));
            chk($sformatf("tbl%0d_cycles", t), 32'(cyc), 32'(tbl[t].beats));
            chk($sformatf("tbl%0d_first_idx", t), {29'b0, first_b.idx}, {29'b0, tbl[t].first_idx});
            chk($sformatf("tbl%0d_first_none", t), {31'b0, first_b.none}, {31'b0, tbl[t].first_none});
        end

        // Backpressure on the second beat of 8'hFF.
        send(8'hFF);
        tick();
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_idx6", {29'b0, out_idx}, LSB_MODE ? 32'd1 : 32'd6);
            chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        drain(cyc);
        chk("stall_beats", 32'(beat_cnt), 32'd8);

        // Reset in the middle of draining 8'hF0.
        send(8'hF0);
        tick();
        chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst_out_idx", {29'b0, out_idx}, 32'd0);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            tick();
            chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
            chk("post_rst_no_beat", {31'b0, out_valid}, 32'd0);
        end

        // Random vectors under random backpressure.
        for (int r = 0; r < 8; r++) begin
            rv = (r == 3) ? '0 : N'($urandom);
            nb = (rv == '0) ? 1 : $countones(rv);
            rand_bp = 1'b1;
            send(rv);
            drain(cyc);
            rand_bp = 1'b0;
            out_ready = 1'b1;
            chk($sformatf("rand%0d_beats", r), 32'(beat_cnt), 32'(nb));
        end

        if (exp_q.size() != 0) fail_now("leftover", "expected beats never produced");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
